uart_mmio_tx: RTL and testbench



---
 rtl/uart_mmio_pkg.sv | 20 ++
 rtl/hex_nibble_to_ascii.sv | 14 +
 rtl/uart_mmio_tx.sv | 112 +++++++++++
 tb/tb_uart_mmio_tx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared types and constants for the MMIO-to-UART byte feeder and its helpers.
package uart_mmio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_BYTE,
        SEND_HEX,
        SEND_CR,
        SEND_LF
    } state_t;

    localparam logic [7:0] CR      = 8'h0D;
    localparam logic [7:0] LF      = 8'h0A;
    localparam logic [7:0] ZERO    = 8'h30;
    localparam logic [7:0] A_LOWER = 8'h61;

    localparam logic [31:0] DEFAULT_BYTE_ADDR = 32'h0000_F000;
    localparam logic [31:0] DEFAULT_HEX_ADDR  = 32'h0000_F004;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational nibble to lowercase ASCII hex digit.
module hex_nibble_to_ascii
    import uart_mmio_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) ascii = ZERO + {4'h0, nibble};
        else                ascii = A_LOWER + {4'h0, nibble} - 8'd10;
    end

endmodule

// File: rtl/uart_mmio_tx.sv
// Turns CPU stores to the byte/hex MMIO registers into UART TX FIFO byte strobes,
// throttled against FIFO occupancy.
module uart_mmio_tx
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BYTE_ADDR      = DEFAULT_BYTE_ADDR,
    parameter logic [31:0] HEX_ADDR       = DEFAULT_HEX_ADDR,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter bit          APPEND_NEWLINE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [7:0]  fifo_size,
    output logic        stall,
    output logic        uart_txd_enable,
    output logic [7:0]  uart_txd_data
);

    // Margin of 3 absorbs the UART's input register and its size-update lag.
    localparam logic [7:0] SPACE_MAX = 8'(FIFO_DEPTH - 3);

    state_t      state, state_next;
    logic [31:0] word;
    logic [2:0]  cnt;
    logic        hit, space;
    logic        emit, capture, capture_hex, cnt_dec;
    logic [7:0]  emit_byte;
    logic [3:0]  nibble;
    logic [7:0]  hex_char;

    assign hit    = mem_write_en & ((mem_addr == BYTE_ADDR) | (mem_addr == HEX_ADDR));
    assign stall  = hit & (state != IDLE);
    assign space  = (fifo_size <= SPACE_MAX);
    assign nibble = word[{cnt, 2'b00} +: 4];

    hex_nibble_to_ascii u_hex (
        .nibble (nibble),
        .ascii  (hex_char)
    );

    always_comb begin
        state_next  = state;
        emit        = 1'b0;
        emit_byte   = word[7:0];
        capture     = 1'b0;
        capture_hex = 1'b0;
        cnt_dec     = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    capture = 1'b1;
                    if (mem_addr == BYTE_ADDR) begin
                        state_next = SEND_BYTE;
                    end else begin
                        capture_hex = 1'b1;
                        state_next  = SEND_HEX;
                    end
                end
            end
            SEND_BYTE: begin
                if (space) begin
                    emit       = 1'b1;
                    state_next = IDLE;
                end
            end
            SEND_HEX: begin
                if (space) begin
                    emit      = 1'b1;
                    emit_byte = hex_char;
                    cnt_dec   = 1'b1;
                    if (cnt == 3'd0) state_next = APPEND_NEWLINE ? SEND_CR : IDLE;
                end
            end
            SEND_CR: begin
                if (space) begin
                    emit       = 1'b1;
                    emit_byte  = CR;
                    state_next = SEND_LF;
                end
            end
            SEND_LF: begin
                if (space) begin
                    emit       = 1'b1;
                    emit_byte  = LF;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            uart_txd_enable <= 1'b0;
            uart_txd_data   <= 8'h00;
            cnt             <= 3'd0;
            word            <= 32'h0;
        end else begin
            state           <= state_next;
            uart_txd_enable <= emit;
            if (emit)    uart_txd_data <= emit_byte;
            if (capture) word <= mem_wdata;
            if (capture_hex)  cnt <= 3'd7;
            else if (cnt_dec) cnt <= cnt - 3'd1;
        end
    end

endmodule

// File: tb/tb_uart_mmio_tx.sv
// Randomized and directed bench for uart_mmio_tx against a byte-stream reference model.
module tb_uart_mmio_tx;

    localparam logic [31:0] BA = 32'h0000_F000;
    localparam logic [31:0] HA = 32'h0000_F004;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0, we0 = 1'b0;
    logic [31:0] addr = '0, wdata = '0, addr0 = '0, wdata0 = '0;
    logic [7:0]  fifo_size = 8'd0;
    logic        stall, en, stall0, en0;
    logic [7:0]  data, data0;

    int   n_pass = 0, n_total = 0;
    bq_t  obs, exp_q, obs0, exp0;
    logic [7:0] fs_prev = 8'd0;
    bit   rnd_on = 1'b0;

    uart_mmio_tx #(.APPEND_NEWLINE(1'b1)) dut (
        .clk(clk), .reset(reset), .mem_write_en(we), .mem_addr(addr), .mem_wdata(wdata),
        .fifo_size(fifo_size), .stall(stall), .uart_txd_enable(en), .uart_txd_data(data)
    );

    uart_mmio_tx #(.APPEND_NEWLINE(1'b0)) dut0 (
        .clk(clk), .reset(reset), .mem_write_en(we0), .mem_addr(addr0), .mem_wdata(wdata0),
        .fifo_size(fifo_size), .stall(stall0), .uart_txd_enable(en0), .uart_txd_data(data0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    // Reference: the byte stream a store must produce, independent of timing.
    function automatic bq_t expand(input logic [31:0] a, input logic [31:0] d, input bit nl);
        bq_t   q;
        string s;
        if (a == BA) q.push_back(d[7:0]);
        else if (a == HA) begin
            s = $sformatf("%08h", d);
            for (int i = 0; i < 8; i++) q.push_back(8'(s[i]));
            if (nl) begin q.push_back(8'h0D); q.push_back(8'h0A); end
        end
        return q;
    endfunction

    always @(posedge clk) fs_prev <= fifo_size;

    always @(negedge clk) begin
        if (en === 1'b1) begin
            obs.push_back(data);
            chk("space_nl", 32'(fs_prev <= 8'd13), 32'd1);
        end
        if (en0 === 1'b1) begin
            obs0.push_back(data0);
            chk("space_nonl", 32'(fs_prev <= 8'd13), 32'd1);
        end
    end

    task automatic cmp_stream(input string tag);
        chk({tag, "_len"}, 32'(obs.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
            chk(tag, 32'(obs[i]), 32'(exp_q[i]));
        obs.delete();
        exp_q.delete();
    endtask

    // CPU store on the newline instance, held while stalled.
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        int  n = 0;
        bq_t q;
        @(posedge clk); #1;
        we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        while (stall && n < 500) begin @(negedge clk); n++; end
        chk("store_accept", 32'(n < 500), 32'd1);
        @(posedge clk); #1;
        we = 1'b0;
        q = expand(a, d, 1'b1);
        foreach (q[i]) exp_q.push_back(q[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t q;
        int  seen, n;
        logic [31:0] a;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // single raw byte: pulse exactly two cycles after store valid
        @(posedge clk); #1;
        we = 1'b1; addr = BA; wdata = 32'h0000_0042;
        @(negedge clk); chk("t1_stall", 32'(stall), 32'd0);
        @(posedge clk); #1 we = 1'b0;
        @(negedge clk); chk("t1_early", 32'(en), 32'd0);
        @(negedge clk); chk("t1_en", 32'(en), 32'd1); chk("t1_data", 32'(data), 32'h42);
        @(negedge clk); chk("t1_once", 32'(en), 32'd0);
        exp_q.push_back(8'h42);
        repeat (3) @(negedge clk);
        cmp_stream("t1");

        // full hex print with newline, colliding store must stall
        @(posedge clk); #1;
        we = 1'b1; addr = HA; wdata = 32'hDEAD_BEEF;
        @(negedge clk); chk("t2_stall0", 32'(stall), 32'd0);
        @(posedge clk); #1 we = 1'b0;
        q = expand(HA, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t2_en", 32'(en), 32'd1);
            chk("t2_data", 32'(data), 32'(q[i]));
            if (i == 3) begin
                we = 1'b1; addr = BA; wdata = 32'h77;
                #1 chk("t2_stall", 32'(stall), 32'd1);
                @(posedge clk); #1 we = 1'b0;
            end
        end
        @(negedge clk); chk("t2_end", 32'(en), 32'd0);
        foreach (q[i]) exp_q.push_back(q[i]);
        cmp_stream("t2");

        // space boundary: 14 blocks, 13 allows
        @(posedge clk); #1 fifo_size = 8'd14;
        store(BA, 32'h5A);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk("t3_hold", 32'(en), 32'd0);
        end
        fifo_size = 8'd13;
        @(negedge clk); chk("t3_pulse", 32'(en), 32'd1); chk("t3_data", 32'(data), 32'h5A);
        fifo_size = 8'd0;
        repeat (2) @(negedge clk);
        cmp_stream("t3");

        // reset in the middle of a hex print
        store(HA, 32'h1234_5678);
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        seen = 0; n = 0;
        while (seen < 3 && n < 100) begin
            @(negedge clk);
            if (en === 1'b1) seen++;
            n++;
        end
        chk("t4_pulses", 32'(seen), 32'd3);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); chk("t4_quiet", 32'(en), 32'd0);
        end
        cmp_stream("t4");
        @(posedge clk); #1;
        we = 1'b1; addr = BA; wdata = 32'h0;
        @(negedge clk); chk("t4_idle", 32'(stall), 32'd0);
        @(posedge clk); #1 we = 1'b0;
        @(negedge clk);
        @(negedge clk); chk("t4_en", 32'(en), 32'd1); chk("t4_data", 32'(data), 32'h00);
        exp_q.push_back(8'h00);
        repeat (2) @(negedge clk);
        cmp_stream("t4b");

        // other address and a read to the byte address do nothing
        @(posedge clk); #1;
        we = 1'b1; addr = 32'h0000_F008; wdata = 32'hFFFF_FFFF;
        #1 chk("t5_other", 32'(stall), 32'd0);
        @(posedge clk); #1;
        we = 1'b0; addr = BA; wdata = 32'h33;
        #1 chk("t5_read", 32'(stall), 32'd0);
        repeat (5) @(negedge clk);
        addr = '0;
        cmp_stream("t5");

        // no-newline instance
        @(posedge clk); #1;
        we0 = 1'b1; addr0 = HA; wdata0 = 32'h0000_0009;
        @(posedge clk); #1 we0 = 1'b0;
        exp0 = expand(HA, 32'h9, 1'b0);
        repeat (20) @(negedge clk);
        chk("t6_len", 32'(obs0.size()), 32'd8);
        for (int i = 0; i < obs0.size() && i < exp0.size(); i++)
            chk("t6_data", 32'(obs0[i]), 32'(exp0[i]));

        // out-of-range occupancy holds forever until it drops
        @(posedge clk); #1 fifo_size = 8'd20;
        store(BA, 32'hC3);
        repeat (10) @(negedge clk);
        chk("t8_hold", 32'(obs.size()), 32'd0);
        fifo_size = 8'd0;
        repeat (3) @(negedge clk);
        cmp_stream("t8");

        // randomized stores under random occupancy
        rnd_on = 1'b1;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 2))
                0:       a = BA;
                1:       a = HA;
                default: a = $urandom | 32'h1;
            endcase
            store(a, $urandom);
        end
        n = 0;
        while (obs.size() < exp_q.size() && n < 3000) begin @(negedge clk); n++; end
        chk("rand_drain", 32'(n < 3000), 32'd1);
        rnd_on = 1'b0;
        @(posedge clk); #2 fifo_size = 8'd0;
        repeat (5) @(negedge clk);
        cmp_stream("rand");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_on)
                fifo_size = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(14, 20))
                                                        : 8'($urandom_range(0, 13));
        end
    end

endmodule
